// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with two-word register window, sticky error flags and level irq
module uart_rx_fifo #(
  parameter int ADDR_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic [7:0]  rx_byte,
  input  logic        addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] write_val,
  output logic [31:0] read_val,
  output logic        irq
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [ADDR_BITS:0]   count_next;
  logic                 ovf, ferr, irq_en;
  logic                 ovf_next, ferr_next, irq_en_next;
  logic                 empty, full, ctrl_wr, flush, pop, push, overflow;
  logic [7:0]           count8;
  logic                 unused_write_bits;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign ctrl_wr  = write_en & addr;
  assign flush    = ctrl_wr & write_val[5];
  assign pop      = read_en & ~addr & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push     = rx_valid & (~full | pop);
  assign overflow = rx_valid & full & ~pop;
  assign count8   = 8'(count);
  assign unused_write_bits = ^{write_val[31:6], write_val[1:0]};

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push & ~pop)
      count_next = count + 1'b1;
    else if (pop & ~push)
      count_next = count - 1'b1;

    // Set sources win over write-1-to-clear; a flushed byte never counts as overflow.
    ovf_next = ovf;
    if (overflow & ~flush)
      ovf_next = 1'b1;
    else if (ctrl_wr & write_val[2])
      ovf_next = 1'b0;

    ferr_next = ferr;
    if (rx_err)
      ferr_next = 1'b1;
    else if (ctrl_wr & write_val[3])
      ferr_next = 1'b0;

    irq_en_next = ctrl_wr ? write_val[4] : irq_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ferr   <= 1'b0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count_next;
      ovf    <= ovf_next;
      ferr   <= ferr_next;
      irq_en <= irq_en_next;
      irq    <= irq_en_next & ((count_next != '0) | ovf_next | ferr_next);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !flush)
      mem[wr_ptr] <= rx_byte;
  end

  always_comb begin
    read_val = '0;
    if (!addr)
      read_val = {23'b0, ~empty, empty ? 8'h00 : mem[rd_ptr]};
    else
      read_val = {16'b0, count8, 3'b0, irq_en, ferr, ovf, full, ~empty};
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based model
module tb_uart_rx_fifo;
  localparam int ADDR_BITS = 4;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        addr = 1'b0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] write_val = '0;
  logic [31:0] read_val;
  logic        irq;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [7:0] q[$];
  bit m_ovf, m_ferr, m_irq_en, m_irq;

  uart_rx_fifo #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_err(rx_err), .rx_byte(rx_byte),
    .addr(addr), .read_en(read_en), .write_en(write_en), .write_val(write_val),
    .read_val(read_val), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic a);
    int n;
    n = q.size();
    if (!a)
      return (n == 0) ? 32'h0 : {23'b0, 1'b1, q[0]};
    return {16'b0, 8'(n), 3'b0, m_irq_en, m_ferr, m_ovf, (n == DEPTH), (n != 0)};
  endfunction

  // Model advances using the inputs held across the edge that just occurred.
  task automatic model_step();
    bit flush, pop_ok, ctrl;
    int n;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_ferr = 0; m_irq_en = 0; m_irq = 0;
      return;
    end
    n      = q.size();
    ctrl   = write_en && addr;
    flush  = ctrl && write_val[5];
    pop_ok = read_en && !addr && n > 0;
    if (flush) begin
      q.delete();
    end else begin
      if (pop_ok) void'(q.pop_front());
      if (rx_valid) begin
        if (n < DEPTH || pop_ok) q.push_back(rx_byte);
        else m_ovf = 1;
      end
    end
    if (!(rx_valid && !flush && n == DEPTH && !pop_ok) && ctrl && write_val[2]) m_ovf = 0;
    if (rx_err) m_ferr = 1;
    else if (ctrl && write_val[3]) m_ferr = 0;
    if (ctrl) m_irq_en = write_val[4];
    m_irq = m_irq_en && (q.size() > 0 || m_ovf || m_ferr);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_read_val", read_val, exp_read(addr));
      check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic idle_inputs();
    rst = 0; rx_valid = 0; rx_err = 0; rx_byte = 8'h00;
    addr = 0; read_en = 0; write_en = 0; write_val = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1; rx_byte = b;
    tick();
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    addr = 1; write_en = 1; write_val = v;
    tick();
  endtask

  task automatic rd_data(input string name, input logic [31:0] exp);
    addr = 0; read_en = 1;
    #1 check(name, read_val, exp);
    tick();
  endtask

  task automatic peek(input string name, input logic a, input logic [31:0] exp);
    addr = a;
    #1 check(name, read_val, exp);
  endtask

  initial begin
    idle_inputs();
    #2;
    rst = 1;
    tick();
    chk_on = 1;

    peek("reset_status", 1'b1, 32'h0);
    peek("reset_data", 1'b0, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    push(8'h41); push(8'h42); push(8'h43);
    peek("three_status", 1'b1, 32'h0000_0301);
    rd_data("read_41", 32'h141);
    rd_data("read_42", 32'h142);
    rd_data("read_43", 32'h143);
    rd_data("read_empty", 32'h000);
    peek("empty_status", 1'b1, 32'h0);

    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hAA);
    peek("ovf_status", 1'b1, 32'h0000_1007);
    for (int i = 0; i < 16; i++) rd_data($sformatf("drain_%0d", i), 32'h100 | i);
    peek("ovf_sticky", 1'b1, 32'h0000_0004);
    wr_ctrl(32'h04);
    peek("ovf_cleared", 1'b1, 32'h0);

    for (int i = 0; i < 16; i++) push(8'(i));
    addr = 0; read_en = 1; rx_valid = 1; rx_byte = 8'h55;
    #1 check("full_pop_push", read_val, 32'h100);
    tick();
    peek("full_pop_push_status", 1'b1, 32'h0000_1003);
    for (int i = 1; i < 16; i++) rd_data($sformatf("drain2_%0d", i), 32'h100 | i);
    rd_data("last_55", 32'h155);

    wr_ctrl(32'h10);
    rx_err = 1;
    tick();
    peek("ferr_status", 1'b1, 32'h0000_0018);
    check("ferr_irq", {31'b0, irq}, 32'h1);
    wr_ctrl(32'h18);
    peek("ferr_cleared", 1'b1, 32'h0000_0010);
    check("ferr_irq_low", {31'b0, irq}, 32'h0);

    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    check("five_irq", {31'b0, irq}, 32'h1);
    rx_valid = 1; rx_byte = 8'h77; addr = 1; write_en = 1; write_val = 32'h20;
    tick();
    peek("flush_status", 1'b1, 32'h0);
    rd_data("flush_data", 32'h000);

    push(8'h11);
    rst = 1; rx_valid = 1; rx_byte = 8'h22; addr = 1; write_en = 1; write_val = 32'h10;
    tick();
    peek("rst_override_status", 1'b1, 32'h0);
    peek("rst_override_data", 1'b0, 32'h0);

    for (int c = 0; c < 4000; c++) begin
      rx_valid = ($urandom_range(0, 99) < 45);
      rx_byte  = 8'($urandom);
      rx_err   = ($urandom_range(0, 99) < 4);
      addr     = 1'($urandom);
      read_en  = ($urandom_range(0, 99) < 40);
      write_en = ($urandom_range(0, 99) < 8);
      write_val = $urandom;
      if ($urandom_range(0, 7) != 0) write_val[5] = 1'b0;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    #1;
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
